// File: rtl/dc_bsp_pkg.sv
// Shared board-support types for the local-memory AVMM write path.
// Holds default local-memory bus widths, the burst arbiter state encoding
// and the channel grant identifier stored in the ack-routing FIFO.
package dc_bsp_pkg;

    localparam int unsigned LOCAL_MEM_ADDR_WIDTH      = 32;
    localparam int unsigned LOCAL_MEM_DATA_WIDTH      = 512;
    localparam int unsigned LOCAL_MEM_BURST_CNT_WIDTH = 7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BURST_A = 2'd1,
        ST_BURST_B = 2'd2
    } arb_state_e;

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_id_e;

endpackage

// File: rtl/avmm_wr_grant_fifo.sv
// Grant-ID FIFO: remembers which input channel owns each outstanding burst so
// output-channel acks can be routed back in issue order.
// Ports:
//   clk, reset        single clock, asynchronous active-high reset
//   push, push_data   enqueue one grant ID (1 bit)
//   pop               dequeue the head entry (ignored when empty)
//   head              show-ahead head entry
//   full, empty       occupancy flags
module avmm_wr_grant_fifo #(
    parameter int unsigned DEPTH = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic push_data,
    input  logic pop,
    output logic head,
    output logic full,
    output logic empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DEPTH-1:0] mem;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             pop_ok;

    assign pop_ok = pop && !empty;
    assign full   = (count == CNT_W'(DEPTH));
    assign empty  = (count == '0);
    assign head   = mem[rd_ptr];

    // Pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop_ok);
        end
    end

    // Storage needs no reset: entries are only read once written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // The arbiter holds off new bursts while full, so overflow must never occur.
    a_no_push_when_full : assert property (@(posedge clk) disable iff (reset) !(push && full));

endmodule

// File: rtl/avmm_wr_burst_arbiter.sv
// Two-to-one AVMM write burst arbiter with in-order ack routing.
// Channels a and b compete for output channel c; a granted burst holds the
// grant until its last beat is accepted. Each burst's owner is queued so that
// c_avmm_wr_ack pulses can be returned to the right channel.
// Ports:
//   clk, reset                      single clock, asynchronous active-high reset
//   {a,b}_avmm_wr/address/burstcnt/writedata   input channel requests
//   {a,b}_avmm_waitreq              backpressure to each input channel
//   {a,b}_avmm_wr_ack               registered one-cycle burst-complete pulse
//   c_avmm_wr/address/burstcnt/writedata       multiplexed output channel
//   c_avmm_waitreq, c_avmm_wr_ack   output-channel backpressure and burst ack
//   ack_underflow_err               sticky: ack seen with nothing outstanding
module avmm_wr_burst_arbiter
    import dc_bsp_pkg::*;
#(
    parameter int unsigned AVMM_ADDR_WIDTH     = LOCAL_MEM_ADDR_WIDTH,
    parameter int unsigned AVMM_DATA_WIDTH     = LOCAL_MEM_DATA_WIDTH,
    parameter int unsigned AVMM_BURSTCNT_WIDTH = LOCAL_MEM_BURST_CNT_WIDTH,
    parameter int unsigned ACK_FIFO_DEPTH      = 64
) (
    input  logic                           clk,
    input  logic                           reset,

    input  logic                           a_avmm_wr,
    output logic                           a_avmm_waitreq,
    input  logic [AVMM_ADDR_WIDTH-1:0]     a_avmm_address,
    input  logic [AVMM_BURSTCNT_WIDTH-1:0] a_avmm_burstcnt,
    input  logic [AVMM_DATA_WIDTH-1:0]     a_avmm_writedata,
    output logic                           a_avmm_wr_ack,

    input  logic                           b_avmm_wr,
    output logic                           b_avmm_waitreq,
    input  logic [AVMM_ADDR_WIDTH-1:0]     b_avmm_address,
    input  logic [AVMM_BURSTCNT_WIDTH-1:0] b_avmm_burstcnt,
    input  logic [AVMM_DATA_WIDTH-1:0]     b_avmm_writedata,
    output logic                           b_avmm_wr_ack,

    output logic                           c_avmm_wr,
    input  logic                           c_avmm_waitreq,
    output logic [AVMM_ADDR_WIDTH-1:0]     c_avmm_address,
    output logic [AVMM_BURSTCNT_WIDTH-1:0] c_avmm_burstcnt,
    output logic [AVMM_DATA_WIDTH-1:0]     c_avmm_writedata,
    input  logic                           c_avmm_wr_ack,

    output logic                           ack_underflow_err
);

    localparam int unsigned BW = AVMM_BURSTCNT_WIDTH;

    arb_state_e      state;
    arb_state_e      state_nxt;
    grant_id_e       last_grant;
    grant_id_e       last_grant_nxt;
    grant_id_e       grant_c;
    logic [BW-1:0]   beat_cnt;
    logic [BW-1:0]   beat_cnt_nxt;
    logic [BW-1:0]   burst_len;
    logic            sel_wr;
    logic            idle_blocked;
    logic            accept;
    logic            push;
    logic            pop;
    logic            fifo_head;
    logic            fifo_full;
    logic            fifo_empty;

    // Grant selection: locked during a burst, round-robin on a tie when idle.
    always_comb begin
        grant_c = GRANT_A;
        case (state)
            ST_BURST_A: grant_c = GRANT_A;
            ST_BURST_B: grant_c = GRANT_B;
            default: begin
                if (a_avmm_wr && b_avmm_wr) begin
                    grant_c = (last_grant == GRANT_A) ? GRANT_B : GRANT_A;
                end else if (b_avmm_wr) begin
                    grant_c = GRANT_B;
                end else begin
                    grant_c = GRANT_A;
                end
            end
        endcase
    end

    // Zero-cycle pass-through of the granted channel.
    always_comb begin
        if (grant_c == GRANT_B) begin
            sel_wr           = b_avmm_wr;
            c_avmm_address   = b_avmm_address;
            c_avmm_burstcnt  = b_avmm_burstcnt;
            c_avmm_writedata = b_avmm_writedata;
        end else begin
            sel_wr           = a_avmm_wr;
            c_avmm_address   = a_avmm_address;
            c_avmm_burstcnt  = a_avmm_burstcnt;
            c_avmm_writedata = a_avmm_writedata;
        end
    end

    // A new burst may not start until the ack FIFO can record its owner.
    assign idle_blocked   = (state == ST_IDLE) && fifo_full;
    assign c_avmm_wr      = !reset && sel_wr && !idle_blocked;
    assign a_avmm_waitreq = reset || (grant_c != GRANT_A) || c_avmm_waitreq || idle_blocked;
    assign b_avmm_waitreq = reset || (grant_c != GRANT_B) || c_avmm_waitreq || idle_blocked;

    assign accept    = c_avmm_wr && !c_avmm_waitreq;
    assign push      = accept && (state == ST_IDLE);
    assign pop       = c_avmm_wr_ack && !fifo_empty;
    assign burst_len = (c_avmm_burstcnt == '0) ? BW'(1) : c_avmm_burstcnt;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            last_grant <= GRANT_B;
            beat_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            beat_cnt   <= beat_cnt_nxt;
        end
    end

    // Next-state: first beat opens a burst, beat_cnt counts remaining beats.
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        beat_cnt_nxt   = beat_cnt;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    last_grant_nxt = grant_c;
                    beat_cnt_nxt   = burst_len - BW'(1);
                    if (burst_len > BW'(1)) begin
                        state_nxt = (grant_c == GRANT_A) ? ST_BURST_A : ST_BURST_B;
                    end
                end
            end
            ST_BURST_A, ST_BURST_B: begin
                if (accept) begin
                    beat_cnt_nxt = beat_cnt - BW'(1);
                    if (beat_cnt == BW'(1)) begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    avmm_wr_grant_fifo #(
        .DEPTH (ACK_FIFO_DEPTH)
    ) u_grant_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (1'(grant_c)),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Ack routing and sticky underflow flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_avmm_wr_ack     <= 1'b0;
            b_avmm_wr_ack     <= 1'b0;
            ack_underflow_err <= 1'b0;
        end else begin
            a_avmm_wr_ack     <= pop && (grant_id_e'(fifo_head) == GRANT_A);
            b_avmm_wr_ack     <= pop && (grant_id_e'(fifo_head) == GRANT_B);
            ack_underflow_err <= ack_underflow_err || (c_avmm_wr_ack && fifo_empty);
        end
    end

endmodule

// File: doc/avmm_wr_burst_arbiter.md
AVMM_WR_BURST_ARBITER -- requirements
Module: avmm_wr_burst_arbiter

Interface
REQ-001 SHALL have parameter AVMM_ADDR_WIDTH, default LOCAL_MEM_ADDR_WIDTH: address width of all channels.
REQ-002 SHALL have parameter AVMM_DATA_WIDTH, default LOCAL_MEM_DATA_WIDTH: writedata width.
REQ-003 SHALL have parameter AVMM_BURSTCNT_WIDTH, default LOCAL_MEM_BURST_CNT_WIDTH: burstcount width.
REQ-004 SHALL have parameter ACK_FIFO_DEPTH, default 64: number of outstanding bursts tracked; power of 2, at least 2.
REQ-005 clk  in  1  single clock for all logic.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 {a,b}_avmm_wr  in  1  write request from input channel a or b.
REQ-008 {a,b}_avmm_waitreq  out  1  backpressure to channel a or b.
REQ-009 {a,b}_avmm_address  in  AVMM_ADDR_WIDTH  burst start address.
REQ-010 {a,b}_avmm_burstcnt  in  AVMM_BURSTCNT_WIDTH  burst length in beats.
REQ-011 {a,b}_avmm_writedata  in  AVMM_DATA_WIDTH  beat data.
REQ-012 {a,b}_avmm_wr_ack  out  1  one pulse per completed burst, routed to the owning channel.
REQ-013 c_avmm_wr, c_avmm_address, c_avmm_burstcnt, c_avmm_writedata  out  (widths as above)  multiplexed output channel.
REQ-014 c_avmm_waitreq  in  1  backpressure from the output channel.
REQ-015 c_avmm_wr_ack  in  1  one pulse per completed output-channel burst, in issue order.
REQ-016 ack_underflow_err  out  1  sticky flag: an ack arrived with no burst outstanding.

Function
REQ-017 Beat accepted SHALL mean c_avmm_wr && !c_avmm_waitreq.
REQ-018 The FSM SHALL have three states: ST_IDLE, ST_BURST_A, ST_BURST_B.
REQ-019 ST_IDLE grant rule: only one channel requesting -> grant that channel; both requesting -> grant the channel that is not last_grant (round-robin).
REQ-020 Output mux SHALL be combinational from the granted channel: zero-cycle pass-through of wr, address, burstcnt and writedata.
REQ-021 Granted channel waitreq SHALL equal c_avmm_waitreq || (ST_IDLE && ack_fifo_full); non-granted channel waitreq SHALL be 1.
REQ-022 In ST_IDLE, c_avmm_wr SHALL be 0 while the ack FIFO is full; no new burst may start until space exists.
REQ-023 On first-beat accept: push the grant ID to the ack FIFO, set last_grant, load beat_cnt = burstcnt-1.
REQ-024 On first-beat accept: if burstcnt > 1, go to ST_BURST_x; otherwise stay in ST_IDLE.
REQ-025 burstcnt 0 SHALL be treated as 1.
REQ-026 In ST_BURST_x the grant SHALL stay locked to x; each accept decrements beat_cnt.
REQ-027 An accept with beat_cnt == 1 SHALL return the FSM to ST_IDLE; the next grant may occur on the following cycle.
REQ-028 Address and burstcnt SHALL be forwarded unmodified on every beat.
REQ-029 c_avmm_wr_ack with the ack FIFO non-empty SHALL pop the FIFO head and pulse the matching {a,b}_avmm_wr_ack for exactly one cycle, one clk after c_avmm_wr_ack (registered).
REQ-030 c_avmm_wr_ack with the ack FIFO empty SHALL set ack_underflow_err, generate no channel ack, and pop nothing.
REQ-031 A push and a pop in the same cycle SHALL both take effect; occupancy stays unchanged.
REQ-032 A push when full is impossible by REQ-022 and SHALL be covered by an assertion.

Reset
REQ-033 Reset SHALL drive, immediately and for its duration: FSM = ST_IDLE, last_grant = B (so A wins the first tie), beat_cnt = 0, ack FIFO empty, {a,b}_avmm_wr_ack = 0, ack_underflow_err = 0, c_avmm_wr = 0, {a,b}_avmm_waitreq = 1.
REQ-034 Reset mid-burst SHALL abandon the burst; the first beat after reset is a new burst start.

Structure
REQ-035 Enum arb_state_e (ST_IDLE, ST_BURST_A, ST_BURST_B) and enum grant_id_e (GRANT_A=0, GRANT_B=1) SHALL live in dc_bsp_pkg.
REQ-036 The grant-ID FIFO SHALL be one sub-module, avmm_wr_grant_fifo: single-clock, 1-bit wide, ACK_FIFO_DEPTH deep, with full/empty flags and show-ahead head.

Verification
REQ-037 A only, burstcnt=4, address=0x100, c_avmm_waitreq=0 -> 4 consecutive beats on c with address 0x100; one c_avmm_wr_ack -> a_avmm_wr_ack pulses 1 cycle later; b_avmm_wr_ack stays 0.
REQ-038 A and B request in the same cycle after reset, burstcnt=2 each -> beats 1-2 from A, beats 3-4 from B; two c acks -> a ack, then b ack.
REQ-039 B burst of 8 with c_avmm_waitreq toggling every cycle; A requests at beat 3 -> a_avmm_waitreq=1 until B's 8th beat is accepted; no interleaving on c.
REQ-040 ACK_FIFO_DEPTH=4, five single-beat A writes, no acks -> fifth write held with waitreq=1; one c_avmm_wr_ack -> fifth beat accepted on a following cycle.
REQ-041 Reset asserted after 2 of 4 beats -> c_avmm_wr=0 in the same cycle, FIFO empty; the next A write is issued as a new burst.
REQ-042 c_avmm_wr_ack with nothing outstanding -> ack_underflow_err=1 and stays 1; no channel ack.
